uart_tx_serializer: RTL
=======================

# uart_tx_serializer

Transmit-side companion of the UART receiver: accepts a parallel byte with a valid strobe and serializes it onto a single line as start bit, LSB-first data, optional parity, and stop bit(s). Bit period is `Prescale` clock cycles, so a receiver on the same `CLK` with the same `Prescale` samples the frame correctly. It sits directly upstream of the receiver, drives its `RX_IN`, and is the stimulus source for the RX loopback environment.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame
- `scaler_width`, 5, width of `Prescale`
- `CLK`  in  1  system clock; all logic on rising edge
- `RST`  in  1  reset: one clock, synchronous, active-high
- `P_DATA`  in  DATA_WIDTH  byte to transmit
- `Data_Valid`  in  1  request; accepted only when `Busy`=0
- `PAR_EN`  in  1  1 = append parity bit
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity
- `Prescale`  in  scaler_width  CLK cycles per bit
- `TX_OUT`  out  1  serial line, idle high, registered
- `Busy`  out  1  frame in progress, registered

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `TX_OUT`=1, `Busy`=0.
  - Accept when `Data_Valid`=1. Latch `P_DATA`, `PAR_EN`, `PAR_TYP`, and the effective prescale. Go to START.
- Effective prescale = `Prescale`, clamped to 4 when `Prescale` < 4.
- Each bit state holds for exactly P cycles (P = latched prescale), timed by a down-counter of width `scaler_width`.
- START: `TX_OUT`=0, then DATA.
- DATA:
  - Bit index counter 0..DATA_WIDTH-1; bit i is driven during slot i (LSB first).
  - After the last bit, go to PARITY if the latched `PAR_EN`=1, else STOP.
- PARITY:
  - `TX_OUT` = XOR-reduce(latched data) XOR latched `PAR_TYP`.
  - This yields even parity for `PAR_TYP`=0 and odd parity for `PAR_TYP`=1.
- STOP: `TX_OUT`=1 for one bit period (two with the macro), then IDLE.
- `Data_Valid` while `Busy`=1 is ignored and the byte is dropped. Upstream holds the request until `Busy`=0.
- Input changes on `P_DATA`, `PAR_EN`, `PAR_TYP`, or `Prescale` mid-frame have no effect on the current frame.
- Reset values: `TX_OUT`=1, `Busy`=0, FSM=IDLE, all counters 0.
- `RST` mid-frame aborts the frame. `TX_OUT`=1 on the cycle after the reset edge. No partial frame resumes.

## Timing
- Acceptance at edge k: `TX_OUT` falls and `Busy` rises at edge k+1. Latency is 1 cycle.
- Frame length N·P cycles, where N = 1 + DATA_WIDTH + PAR_EN + stop bits.
- The start bit occupies cycles k+1 .. k+P.
- `Busy` stays high through the final stop cycle and falls at edge k+N·P+1, when the FSM returns to IDLE.
- Back-to-back: a request held high is accepted at edge k+N·P+1 and starts at k+N·P+2. This gives exactly one idle-high cycle between frames.
- `RST` asserted together with `Data_Valid`: reset wins and nothing is accepted.

## Configuration
- Macro: `UART_TX_STOP2_EN`.
- Defined: STOP lasts 2·P cycles, and N counts 2 stop bits.
- Undefined: a single stop bit.
- A single-stop receiver reads the second stop bit as idle line, so both builds are receiver-compatible.

## Test plan
- `Prescale`=8, `PAR_EN`=1, `PAR_TYP`=0, `P_DATA`=0xA5 ->
  - line bits 0,1,0,1,0,0,1,0,1,0,1, each 8 cycles, 88 cycles total;
  - `Busy` high for cycles 1..88.
- `Prescale`=16, `PAR_EN`=0, `P_DATA`=0xFF ->
  - 1 start bit, 8 ones, 1 stop bit;
  - 160 cycles; `Busy` falls on cycle 161.
- `PAR_TYP`=1, `P_DATA`=0x01 -> parity bit 0. `P_DATA`=0x03 -> parity bit 1.
- `Data_Valid` held high with 0x11 then 0x22; pulse 0x33 mid-frame ->
  - 0x11 and 0x22 are sent with a 1-cycle idle gap;
  - 0x33 never appears on the line.
- `RST` pulsed during data bit 3 ->
  - `TX_OUT`=1 and `Busy`=0 the next cycle;
  - a following request for 0x5A transmits a clean frame.
- Loopback into the receiver at `Prescale`=8, 256 random bytes, random `PAR_EN`/`PAR_TYP` ->
  - every byte appears on `P_DATA` with `data_valid`;
  - no parity or stop errors.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: serializes a parallel byte as start, LSB-first data, optional parity, stop bit(s).
// Latency: TX_OUT falls and Busy rises one cycle after the accepting edge; each bit lasts P cycles.
// Backpressure: Data_Valid is only accepted in IDLE; requests while Busy are dropped.
// Build option: define UART_TX_STOP2_EN for two stop bits (default: one).
module uart_tx_serializer #(
   parameter int DATA_WIDTH   = 8,
   parameter int scaler_width = 5
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   P_DATA,
   input  logic                    Data_Valid,
   input  logic                    PAR_EN,
   input  logic                    PAR_TYP,
   input  logic [scaler_width-1:0] Prescale,
   output logic                    TX_OUT,
   output logic                    Busy
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                  state, state_nxt;
   logic [scaler_width-1:0] cnt, cnt_nxt;
   logic [scaler_width-1:0] presc_q, presc_nxt;
   logic [scaler_width-1:0] presc_eff;
   logic [scaler_width-1:0] reload;
   logic [IDX_W-1:0]        bit_idx, bit_idx_nxt;
   logic [DATA_WIDTH-1:0]   data_q, data_nxt;
   logic                    par_en_q, par_en_nxt;
   logic                    par_typ_q, par_typ_nxt;
   logic                    slot_end;
   logic                    tx_d;
`ifdef UART_TX_STOP2_EN
   logic                    stop_second, stop_second_nxt;
`endif

   // Prescale below 4 is too short for the receiver's mid-bit sampling, so it is clamped.
   assign presc_eff = (Prescale < scaler_width'(4)) ? scaler_width'(4) : Prescale;
   assign reload    = presc_q - scaler_width'(1);
   assign slot_end  = (cnt == '0);

   // Next-state logic: bit timing down-counter, bit index and frame sequencing.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      presc_nxt   = presc_q;
      bit_idx_nxt = bit_idx;
      data_nxt    = data_q;
      par_en_nxt  = par_en_q;
      par_typ_nxt = par_typ_q;
`ifdef UART_TX_STOP2_EN
      stop_second_nxt = stop_second;
`endif
      // Every bit state counts down and reloads at the end of its slot.
      if (state != IDLE) begin
         cnt_nxt = slot_end ? reload : cnt - scaler_width'(1);
      end
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (Data_Valid) begin
               // Snapshot all frame parameters so mid-frame input changes are harmless.
               data_nxt    = P_DATA;
               par_en_nxt  = PAR_EN;
               par_typ_nxt = PAR_TYP;
               presc_nxt   = presc_eff;
               cnt_nxt     = presc_eff - scaler_width'(1);
               bit_idx_nxt = '0;
               state_nxt   = START;
            end
         end
         START: begin
            if (slot_end) state_nxt = DATA;
         end
         DATA: begin
            if (slot_end) begin
               if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                  bit_idx_nxt = '0;
                  state_nxt   = par_en_q ? PARITY : STOP;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (slot_end) state_nxt = STOP;
         end
         STOP: begin
            if (slot_end) begin
`ifdef UART_TX_STOP2_EN
               if (!stop_second) begin
                  stop_second_nxt = 1'b1;
               end else begin
                  stop_second_nxt = 1'b0;
                  cnt_nxt         = '0;
                  state_nxt       = IDLE;
               end
`else
               cnt_nxt   = '0;
               state_nxt = IDLE;
`endif
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Line level for the current state; registered below so TX_OUT trails the state by one cycle.
   always_comb begin
      tx_d = 1'b1;
      case (state)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_q[bit_idx];
         PARITY:  tx_d = (^data_q) ^ par_typ_q;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   // State, datapath and registered outputs; reset aborts any frame and idles the line.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         presc_q   <= '0;
         bit_idx   <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         TX_OUT    <= 1'b1;
         Busy      <= 1'b0;
`ifdef UART_TX_STOP2_EN
         stop_second <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         presc_q   <= presc_nxt;
         bit_idx   <= bit_idx_nxt;
         data_q    <= data_nxt;
         par_en_q  <= par_en_nxt;
         par_typ_q <= par_typ_nxt;
         TX_OUT    <= tx_d;
         Busy      <= (state != IDLE);
`ifdef UART_TX_STOP2_EN
         stop_second <= stop_second_nxt;
`endif
      end
   end

endmodule
